// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and
// data requests. A grant is latched in IDLE, held until the RAM reports
// ACCESS or ERROR, and returned to IDLE for at least one cycle afterwards.
// Optional feature macro: MEM_ARB_FAIRNESS_EN. When it is defined, a
// starved fetch is forced in after MAX_DATA_STREAK data hits.
module mem_arbiter #(
    parameter int WORD_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic [1:0]        ramstate,
    input  logic [WORD_W-1:0] ramload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    output logic              ihit,
    output logic [WORD_W-1:0] iload,
    output logic              dhit,
    output logic [WORD_W-1:0] dload,
    output logic              ram_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    if (MAX_DATA_STREAK < 1) begin : g_bad_param
        $error("mem_arbiter: MAX_DATA_STREAK must be at least 1");
    end

    state_t state_q, state_d;
    logic   ram_err_q;
    logic   err_set;
    logic   fair_force;

    assign ram_err = ram_err_q;

    // Next state plus RAM steering; everything idles at zero outside a grant
    always_comb begin
        state_d  = state_q;
        err_set  = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        case (state_q)
            IDLE: begin
                if (fair_force)        state_d = IGRANT;
                else if (dREN || dWEN) state_d = DGRANT;
                else if (iREN)         state_d = IGRANT;
            end
            DGRANT: begin
                if (!(dREN || dWEN)) begin
                    // requester withdrew: drop enables now, no hit
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS) begin
                        dhit    = 1'b1;
                        dload   = ramload;
                        state_d = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        ihit    = 1'b1;
                        iload   = ramload;
                        state_d = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and sticky error flag, both cleared only by reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ram_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) ram_err_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Count data hits that made a waiting fetch wait; saturate at the limit
    always_comb begin
        streak_d = streak_q;
        if (ihit || (state_q == IDLE && !iREN))
            streak_d = '0;
        else if (dhit && iREN && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
    end

    // Streak register
    always_ff @(posedge CLK) begin
        if (!nRST) streak_q <= '0;
        else       streak_q <= streak_d;
    end

    assign fair_force = iREN && (streak_q == STREAK_MAX);
`else
    assign fair_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level requester/RAM model.
module tb_mem_arbiter;

    localparam int W = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam logic [31:0] MAGIC = 32'h5A5A_0F0F;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]   ramstate;
    logic         ramREN, ramWEN, ihit, dhit, ram_err;
    logic [W-1:0] ramaddr, ramstore, iload, dload;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.WORD_W(W), .MAX_DATA_STREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ram_err(ram_err)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
        cyc();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
        #1;
        n_chk++;
        if ({ramREN, ramWEN, ihit, dhit, ram_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000", {ramREN, ramWEN, ihit, dhit, ram_err});
        end
        n_chk++;
        if ({ramaddr, ramstore, iload, dload} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore, iload, dload});
        end
        ramstate = FREE;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        dREN = 1; daddr = 32'h10;
        cyc();
        ramstate = BUSY;
        #1;
        n_chk++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_grant_en: ramREN=%b want 1", ramREN);
        end
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        #1;
        n_chk++;
        if ({ramREN, ramWEN, dhit} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_grant_idle: {ren,wen,dhit}=%b want 000", {ramREN, ramWEN, dhit});
        end
        dREN = 0;
        cyc();
    endtask

    task automatic test_single_fetch();
        do_reset();
        iREN = 1; iaddr = 32'h40;
        #1;
        n_chk++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL fetch_idle: ramREN=%b want 0", ramREN);
        end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 3) begin ramstate = ACCESS; ramload = 32'hDEAD_BEEF; end
            else        begin ramstate = BUSY;   ramload = 32'h1111_1111; end
            #1;
            n_chk++;
            if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
                n_fail++; $display("FAIL fetch_addr c%0d: ren=%b wen=%b addr=%h want 1 0 00000040", c, ramREN, ramWEN, ramaddr);
            end
            n_chk++;
            if (ihit !== (c == 3)) begin
                n_fail++; $display("FAIL fetch_hit c%0d: ihit=%b want %b", c, ihit, c == 3);
            end
        end
        n_chk++;
        if (iload !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fetch_iload: got %h want deadbeef", iload);
        end
        iREN = 0;
        cyc();
        ramstate = FREE;
        #1;
        n_chk++;
        if ({ihit, ramREN} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_after: {ihit,ren}=%b want 00", {ihit, ramREN});
        end
    endtask

    task automatic test_contention();
        do_reset();
        iREN = 1; iaddr = 32'h44;
        dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        ramstate = ACCESS; ramload = 32'hCAFE_F00D;
        cyc();
        #1;
        n_chk++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dhit, ihit} !== {2'b10, 32'h80, 32'h1234, 2'b10}) begin
            n_fail++;
            $display("FAIL contend_data: wen=%b ren=%b addr=%h store=%h dhit=%b ihit=%b want 1 0 80 1234 1 0",
                     ramWEN, ramREN, ramaddr, ramstore, dhit, ihit);
        end
        dWEN = 0;
        cyc();
        #1;
        n_chk++;
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
            n_fail++; $display("FAIL contend_idle: {ren,wen,ihit,dhit}=%b want 0000", {ramREN, ramWEN, ihit, dhit});
        end
        cyc();
        #1;
        n_chk++;
        if ({ramREN, ramaddr, ihit, iload} !== {1'b1, 32'h44, 1'b1, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL contend_fetch: ren=%b addr=%h ihit=%b iload=%h want 1 44 1 cafef00d",
                               ramREN, ramaddr, ihit, iload);
        end
        iREN = 0;
        cyc();
    endtask

    task automatic test_error();
        do_reset();
        dREN = 1; daddr = 32'h300;
        cyc();
        ramstate = ERROR;
        #1;
        n_chk++;
        if (dhit !== 1'b0) begin
            n_fail++; $display("FAIL err_nohit: dhit=%b want 0", dhit);
        end
        cyc();
        ramstate = FREE;
        #1;
        n_chk++;
        if ({ram_err, ramREN} !== 2'b10) begin
            n_fail++; $display("FAIL err_flag: {ram_err,ren}=%b want 10", {ram_err, ramREN});
        end
        cyc();
        ramstate = ACCESS; ramload = 32'h55AA_33CC;
        #1;
        n_chk++;
        if ({dhit, dload, ram_err} !== {1'b1, 32'h55AA_33CC, 1'b1}) begin
            n_fail++; $display("FAIL err_retry: dhit=%b dload=%h ram_err=%b want 1 55aa33cc 1", dhit, dload, ram_err);
        end
        dREN = 0;
        cyc();
        ramstate = FREE;
        #1;
        n_chk++;
        if (ram_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: ram_err=%b want 1", ram_err);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        dREN = 1; daddr = 32'h400;
        cyc();
        ramstate = BUSY;
        #1;
        n_chk++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL wd_grant: ramREN=%b want 1", ramREN);
        end
        dREN = 0;
        #1;
        n_chk++;
        if ({ramREN, dhit} !== 2'b00) begin
            n_fail++; $display("FAIL wd_drop: {ren,dhit}=%b want 00", {ramREN, dhit});
        end
        cyc();
        dREN = 1;
        #1;
        n_chk++;
        if ({ramREN, dhit} !== 2'b00) begin
            n_fail++; $display("FAIL wd_idle: {ren,dhit}=%b want 00", {ramREN, dhit});
        end
        cyc();
        #1;
        n_chk++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL wd_regrant: ramREN=%b want 1", ramREN);
        end
        dREN = 0;
        cyc();
    endtask

    task automatic test_fairness();
        byte hits[$];
        do_reset();
        iREN = 1; iaddr = 32'h100;
        dREN = 1; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h77;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ihit && dhit) hits.push_back("B");
            else if (ihit)    hits.push_back("I");
            else if (dhit)    hits.push_back("D");
            cyc();
        end
        n_chk++;
        if (hits.size() != 10) begin
            n_fail++; $display("FAIL fair_count: %0d hits want 10", hits.size());
        end
        for (int j = 0; j < hits.size() && j < 10; j++) begin
            byte want;
`ifdef MEM_ARB_FAIRNESS_EN
            want = (j % 5 == 4) ? "I" : "D";
`else
            want = "D";
`endif
            n_chk++;
            if (hits[j] != want) begin
                n_fail++; $display("FAIL fair_seq[%0d]: got %c want %c", j, hits[j], want);
            end
        end
        iREN = 0; dREN = 0;
        cyc();
    endtask

    task automatic test_random();
        int   i_gap = 0, d_gap = 0, ram_wait = 0, i_wait = 0, d_wait = 0;
        int   n_dreq = 0, n_dhit = 0, n_ireq = 0, n_ihit = 0;
        bit   ihit_p = 0, dhit_p = 0, en_p = 0, dpend_p = 0, en, gd;
        logic [31:0] tmp;
        do_reset();
        #1;
        n_chk++;
        if (ram_err !== 1'b0) begin
            n_fail++; $display("FAIL rnd_reset_err: ram_err=%b want 0", ram_err);
        end
        for (int k = 0; k < 600; k++) begin
            cyc();
            // fetch requester: holds until hit, then rests at least a cycle
            if (ihit_p) begin
                iREN = 0; i_gap = $urandom_range(1, 3);
            end else if (!iREN) begin
                if (i_gap > 0) i_gap--;
                if (i_gap == 0 && $urandom_range(0, 1) == 1) begin
                    tmp = $urandom(); iaddr = {1'b0, tmp[30:2], 2'b00};
                    iREN = 1; i_wait = 0; n_ireq++;
                end
            end
            // data requester: random reads and writes in the upper half
            if (dhit_p) begin
                dREN = 0; dWEN = 0; d_gap = $urandom_range(1, 3);
            end else if (!(dREN || dWEN)) begin
                if (d_gap > 0) d_gap--;
                if (d_gap == 0 && $urandom_range(0, 1) == 1) begin
                    tmp = $urandom(); daddr = {1'b1, tmp[30:2], 2'b00};
                    dstore = $urandom();
                    if ($urandom_range(0, 1) == 1) begin dWEN = 1; dREN = 0; end
                    else                           begin dREN = 1; dWEN = 0; end
                    d_wait = 0; n_dreq++;
                end
            end
            ramstate = FREE; ramload = $urandom();
            #1;
            en = ramREN || ramWEN;
            if (en && !en_p) begin
                ram_wait = $urandom_range(0, 3);
                gd = ramaddr[31];
`ifndef MEM_ARB_FAIRNESS_EN
                n_chk++;
                if (gd !== dpend_p) begin
                    n_fail++; $display("FAIL rnd_priority @%0d: data_grant=%b data_pending=%b", k, gd, dpend_p);
                end
`endif
                n_chk++;
                if (gd ? ({ramaddr, ramREN, ramWEN} !== {daddr, dREN, dWEN}) || (dWEN && ramstore !== dstore)
                       : ({ramaddr, ramREN, ramWEN} !== {iaddr, 2'b10})) begin
                    n_fail++;
                    $display("FAIL rnd_steer @%0d: addr=%h ren=%b wen=%b store=%h want iaddr=%h daddr=%h dstore=%h",
                             k, ramaddr, ramREN, ramWEN, ramstore, iaddr, daddr, dstore);
                end
            end
            if (en) begin
                if (ram_wait == 0) begin ramstate = ACCESS; ramload = ramaddr ^ MAGIC; end
                else               begin ramstate = BUSY;   ram_wait--; end
            end
            #1;
            n_chk++;
            if ((ihit || dhit) !== (ramstate == ACCESS) || (ihit && dhit)) begin
                n_fail++; $display("FAIL rnd_hit @%0d: ihit=%b dhit=%b ramstate=%0d", k, ihit, dhit, ramstate);
            end
            if (dhit) begin
                n_dhit++;
                n_chk++;
                if (dload !== (daddr ^ MAGIC)) begin
                    n_fail++; $display("FAIL rnd_dload @%0d: got %h want %h", k, dload, daddr ^ MAGIC);
                end
            end
            if (ihit) begin
                n_ihit++;
                n_chk++;
                if (iload !== (iaddr ^ MAGIC)) begin
                    n_fail++; $display("FAIL rnd_iload @%0d: got %h want %h", k, iload, iaddr ^ MAGIC);
                end
            end
            if (iREN && !ihit) i_wait++;
            if ((dREN || dWEN) && !dhit) d_wait++;
            if (i_wait == 60 || d_wait == 60) begin
                n_chk++; n_fail++;
                $display("FAIL rnd_timeout @%0d: i_wait=%0d d_wait=%0d", k, i_wait, d_wait);
                i_wait++; d_wait++;
            end
            ihit_p = ihit; dhit_p = dhit; en_p = en; dpend_p = dREN || dWEN;
        end
        n_chk++;
        if (n_dhit != n_dreq - ((dREN || dWEN) && !dhit_p ? 1 : 0)) begin
            n_fail++; $display("FAIL rnd_dcount: %0d hits for %0d requests", n_dhit, n_dreq);
        end
        n_chk++;
        if (n_ihit != n_ireq - (iREN && !ihit_p ? 1 : 0)) begin
            n_fail++; $display("FAIL rnd_icount: %0d hits for %0d requests", n_ihit, n_ireq);
        end
        n_chk++;
        if (ram_err !== 1'b0) begin
            n_fail++; $display("FAIL rnd_err: ram_err=%b want 0", ram_err);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_single_fetch();
        test_contention();
        test_error();
        test_withdraw();
        test_fairness();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
